// File: rtl/dshot_encoder_pkg.sv
// dshot_encoder_pkg
//   Shared definitions for the DShot encoder: FSM state encoding, DShot value
//   limits, the Q4.28 throttle format and the 4-bit frame checksum.
package dshot_encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int DSHOT_MIN_THROTTLE = 48;
  localparam int DSHOT_MAX          = 2047;
  localparam int DSHOT_SCALE        = 1999;
  localparam int DSHOT_CMD_MAX      = 47;
  localparam int Q_FRAC_BITS        = 28;
  localparam logic [31:0] Q_ONE     = 32'h1000_0000;
  localparam int FRAME_BITS         = 16;

  // XOR of the three nibbles of {value, telem}.
  function automatic logic [3:0] dshot_crc(input logic [11:0] v);
    return v[3:0] ^ v[7:4] ^ v[11:8];
  endfunction

endpackage

// File: rtl/dshot_encoder_if.sv
// dshot_encoder_if
//   Request channel from the flight-loop scheduler / mixer into one encoder.
//   in_valid/in_ready  : handshake, transfer on an edge with both high
//   throttle           : signed Q4.28 mixed throttle
//   is_cmd/cmd_code    : send a DShot special command instead of throttle
//   telem              : telemetry request bit
interface dshot_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] throttle;
  logic        is_cmd;
  logic [5:0]  cmd_code;
  logic        telem;

  modport master (
    output in_valid, throttle, is_cmd, cmd_code, telem,
    input  in_ready
  );

  modport slave (
    input  in_valid, throttle, is_cmd, cmd_code, telem,
    output in_ready
  );
endinterface

// File: rtl/dshot_frame_builder.sv
// dshot_frame_builder
//   Purely combinational: turns one request into a 16-bit DShot frame.
//   throttle : in  signed Q4.28, clamped to [0, 1.0] and scaled to 48..2047
//   is_cmd   : in  1 = use cmd_code verbatim (values above 47 become 0)
//   cmd_code : in  special command code
//   telem    : in  telemetry request bit
//   frame    : out {value[10:0], telem, crc[3:0]}, MSB transmitted first
module dshot_frame_builder
  import dshot_encoder_pkg::*;
(
  input  logic [31:0] throttle,
  input  logic        is_cmd,
  input  logic [5:0]  cmd_code,
  input  logic        telem,
  output logic [15:0] frame
);

  localparam logic [28:0] X_MAX = Q_ONE[28:0];

  logic        positive;
  logic [28:0] x;
  logic [42:0] product;
  logic [10:0] scaled;
  logic [10:0] value;
  logic [11:0] v;

  always_comb begin
    positive = ($signed(throttle) > 0);
    x        = '0;
    if (positive) begin
      x = (throttle > Q_ONE) ? X_MAX : throttle[28:0];
    end
    // x <= 2^28, so (x * 1999) >> 28 never exceeds 1999 and fits in 11 bits.
    product = {14'b0, x} * 43'(DSHOT_SCALE);
    scaled  = 11'(product >> Q_FRAC_BITS);

    value = '0;
    if (is_cmd) begin
      if (cmd_code <= 6'(DSHOT_CMD_MAX)) begin
        value = {5'b0, cmd_code};
      end
    end else if (positive) begin
      value = 11'(DSHOT_MIN_THROTTLE) + scaled;
    end

    v     = {value, telem};
    frame = {v, dshot_crc(v)};
  end

endmodule

// File: rtl/dshot_encoder.sv
// dshot_encoder
//   One motor channel: accepts a request over the slave handshake, latches the
//   frame built from it, serialises the 16 bits MSB first as DShot pulses and
//   then holds the line low for a fixed gap before accepting the next request.
//   clk        : in  system clock
//   reset      : in  asynchronous, active-high reset
//   bus        : slave side of dshot_encoder_if (request + in_ready)
//   dshot_out  : out registered serial line to the ESC
//   busy       : out frame or gap in progress
//   frame_done : out one-cycle pulse on the last gap cycle
module dshot_encoder
  import dshot_encoder_pkg::*;
#(
  parameter int BIT_TICKS = 80,
  parameter int T0H_TICKS = 30,
  parameter int T1H_TICKS = 60,
  parameter int GAP_TICKS = 96
) (
  input  logic           clk,
  input  logic           reset,
  dshot_encoder_if.slave bus,
  output logic           dshot_out,
  output logic           busy,
  output logic           frame_done
);

  generate
    if (!(T0H_TICKS > 0 && T0H_TICKS < T1H_TICKS && T1H_TICKS < BIT_TICKS && GAP_TICKS >= 1)) begin : g_bad_params
      $error("dshot_encoder: illegal timing parameters");
    end
  endgenerate

  // One counter serves both the per-bit tick and the gap length.
  localparam int CNT_MAX = (BIT_TICKS > GAP_TICKS) ? BIT_TICKS : GAP_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_TICKS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_TICKS - 1);
  localparam logic [CNT_W-1:0] T0H_CNT  = CNT_W'(T0H_TICKS);
  localparam logic [CNT_W-1:0] T1H_CNT  = CNT_W'(T1H_TICKS);

  state_t           state_reg, state_next;
  logic [15:0]      frame_reg;
  logic [3:0]       bit_reg;
  logic [CNT_W-1:0] tick_reg;
  logic             dshot_out_reg;
  logic [15:0]      frame_built;
  logic             accept;
  logic             bit_end;
  logic             send_high;

  dshot_frame_builder u_builder (
    .throttle (bus.throttle),
    .is_cmd   (bus.is_cmd),
    .cmd_code (bus.cmd_code),
    .telem    (bus.telem),
    .frame    (frame_built)
  );

  assign accept    = (state_reg == ST_IDLE) && bus.in_valid;
  assign bit_end   = (tick_reg == BIT_LAST);
  assign send_high = (state_reg == ST_SEND) &&
                     (tick_reg < (frame_reg[bit_reg] ? T1H_CNT : T0H_CNT));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (bus.in_valid) state_next = ST_SEND;
      ST_SEND: if (bit_end && bit_reg == 4'd0) state_next = ST_GAP;
      ST_GAP:  if (tick_reg == GAP_LAST) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.in_ready = (state_reg == ST_IDLE);
    busy         = (state_reg != ST_IDLE);
    frame_done   = (state_reg == ST_GAP) && (tick_reg == GAP_LAST);
    dshot_out    = dshot_out_reg;
  end

  // Datapath: frame latch, counters and the registered line driver. The line
  // is registered from the counters, so the first high appears one edge after
  // the accept edge and the 16 bit periods end one edge after SEND does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_reg     <= '0;
      bit_reg       <= '0;
      tick_reg      <= '0;
      dshot_out_reg <= 1'b0;
    end else begin
      dshot_out_reg <= send_high;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            frame_reg <= frame_built;
            bit_reg   <= 4'(FRAME_BITS - 1);
            tick_reg  <= '0;
          end
        end
        ST_SEND: begin
          // Leaving SEND after bit 0 also zeroes the tick for the gap count.
          if (bit_end) begin
            tick_reg <= '0;
            bit_reg  <= bit_reg - 4'd1;
          end else begin
            tick_reg <= tick_reg + 1'b1;
          end
        end
        ST_GAP:  tick_reg <= tick_reg + 1'b1;
        default: ;
      endcase
    end
  end

endmodule
